// File: rtl/axi_gpio_slave.sv
// AXI4-Lite GPIO slave: OUT (rw), IN (ro, synchronized pins) and DIR (rw)
// registers, with independent write and read channels and registered handshakes.
module axi_gpio_slave #(
  parameter int N_GPIO = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_AWADDR,
  input  logic [2:0]        S_AXI_AWPROT,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  output logic [1:0]        S_AXI_BRESP,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  input  logic [31:0]       S_AXI_ARADDR,
  input  logic [2:0]        S_AXI_ARPROT,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  input  logic [N_GPIO-1:0] gpio_in,
  output logic [N_GPIO-1:0] gpio_out,
  output logic [N_GPIO-1:0] gpio_oe
);

  localparam int         DATA_W      = 32;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] REG_OUT     = 2'd0;
  localparam logic [1:0] REG_IN      = 2'd1;
  localparam logic [1:0] REG_DIR     = 2'd2;

  // Byte-lane merge of write data into a register; lanes above N_GPIO fall away.
  function automatic logic [N_GPIO-1:0] apply_strb(
    input logic [N_GPIO-1:0] cur,
    input logic [DATA_W-1:0] wdata,
    input logic [3:0]        strb
  );
    logic [DATA_W-1:0] merged;
    merged = DATA_W'(cur);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return N_GPIO'(merged);
  endfunction

  logic              init_done;
  logic [N_GPIO-1:0] out_q;
  logic [N_GPIO-1:0] dir_q;
  logic [N_GPIO-1:0] sync_p0;
  logic [N_GPIO-1:0] sync_p1;

  logic              aw_held_q;
  logic              w_held_q;
  logic [1:0]        aw_sel_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;

  logic              aw_hs;
  logic              w_hs;
  logic              wr_exec;
  logic              wr_ok;
  logic [1:0]        wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        wr_strb;
  logic              aw_held_d;
  logic              w_held_d;
  logic              bvalid_d;

  logic              ar_hs;
  logic              rvalid_d;
  logic [DATA_W-1:0] rd_data_c;
  logic [1:0]        rd_resp_c;

  logic              unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[31:4], S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[31:4], S_AXI_ARADDR[1:0]};

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;

  // Stage p0/p1: two-flop synchronizer on the asynchronous pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= gpio_in;
      sync_p1 <= sync_p0;
    end
  end

  // A write fires on the edge that completes the AW/W pair, using whichever
  // half is arriving live and whichever half was captured earlier.
  assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
  assign wr_exec = (aw_hs | aw_held_q) & (w_hs | w_held_q);
  assign wr_sel  = aw_hs ? S_AXI_AWADDR[3:2] : aw_sel_q;
  assign wr_data = w_hs ? S_AXI_WDATA : wdata_q;
  assign wr_strb = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign wr_ok   = (wr_sel == REG_OUT) || (wr_sel == REG_DIR);

  always_comb begin
    aw_held_d = aw_held_q | aw_hs;
    w_held_d  = w_held_q | w_hs;
    bvalid_d  = S_AXI_BVALID & ~S_AXI_BREADY;
    if (wr_exec) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_done     <= 1'b0;
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      out_q         <= '0;
      dir_q         <= '0;
    end else begin
      // READYs stay low for the first edge after release, gated by init_done.
      init_done     <= 1'b1;
      aw_held_q     <= aw_held_d;
      w_held_q      <= w_held_d;
      S_AXI_AWREADY <= init_done & ~aw_held_d & ~bvalid_d;
      S_AXI_WREADY  <= init_done & ~w_held_d & ~bvalid_d;
      S_AXI_BVALID  <= bvalid_d;
      if (wr_exec) begin
        S_AXI_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_sel == REG_OUT) out_q <= apply_strb(out_q, wr_data, wr_strb);
        if (wr_sel == REG_DIR) dir_q <= apply_strb(dir_q, wr_data, wr_strb);
      end
    end
  end

  // Payload holding registers; only meaningful while the matching held flag is set.
  always_ff @(posedge clk) begin
    if (aw_hs) aw_sel_q <= S_AXI_AWADDR[3:2];
    if (w_hs) begin
      wdata_q <= S_AXI_WDATA;
      wstrb_q <= S_AXI_WSTRB;
    end
  end

  // Read mux sees the registers before any same-edge write lands.
  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    case (S_AXI_ARADDR[3:2])
      REG_OUT: rd_data_c = DATA_W'(out_q);
      REG_IN:  rd_data_c = DATA_W'(sync_p1);
      REG_DIR: rd_data_c = DATA_W'(dir_q);
      default: rd_resp_c = RESP_SLVERR;
    endcase
  end

  assign ar_hs    = S_AXI_ARVALID & S_AXI_ARREADY;
  assign rvalid_d = ar_hs | (S_AXI_RVALID & ~S_AXI_RREADY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      S_AXI_ARREADY <= init_done & ~rvalid_d;
      S_AXI_RVALID  <= rvalid_d;
      if (ar_hs) begin
        S_AXI_RDATA <= rd_data_c;
        S_AXI_RRESP <= rd_resp_c;
      end
    end
  end

endmodule

// File: tb/tb_axi_gpio_slave.sv
// Bench for axi_gpio_slave: vector table of register accesses plus hand-written
// sequences for ordering, backpressure, same-edge read/write and mid-transaction reset.
module tb_axi_gpio_slave;

  logic        clk;
  logic        reset;
  logic        S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic [15:0] gpio_in, gpio_out, gpio_oe;

  axi_gpio_slave #(.N_GPIO(16)) dut (
    .clk(clk), .reset(reset),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    int          lead;      // >0: W leads AW by this many cycles, <0: AW leads W
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [15:0] exp_out;
    logic [15:0] exp_oe;
  } vec_t;

  vec_t        vecs[15];
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, 32'(S_AXI_AWREADY), 0);
    chk({tag, "_wready"},  32'(S_AXI_WREADY), 0);
    chk({tag, "_arready"}, 32'(S_AXI_ARREADY), 0);
    chk({tag, "_bvalid"},  32'(S_AXI_BVALID), 0);
    chk({tag, "_rvalid"},  32'(S_AXI_RVALID), 0);
    chk({tag, "_bresp"},   32'(S_AXI_BRESP), 0);
    chk({tag, "_rresp"},   32'(S_AXI_RRESP), 0);
    chk({tag, "_rdata"},   S_AXI_RDATA, 0);
    chk({tag, "_gpio_out"}, 32'(gpio_out), 0);
    chk({tag, "_gpio_oe"},  32'(gpio_oe), 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int lead);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    int aw_start = (lead > 0) ? lead : 0;
    int w_start  = (lead < 0) ? -lead : 0;
    int n = 0;
    logic [31:0] snap = {gpio_out, gpio_oe};
    while (!(aw_done && w_done) && n < 40) begin
      if (!aw_done && n >= aw_start) begin S_AXI_AWVALID = 1; S_AXI_AWADDR = a; end
      if (!w_done && n >= w_start) begin
        S_AXI_WVALID = 1; S_AXI_WDATA = d; S_AXI_WSTRB = s;
      end
      aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
      w_f  = S_AXI_WVALID && S_AXI_WREADY;
      step();
      if (aw_f) begin aw_done = 1; S_AXI_AWVALID = 0; end
      if (w_f)  begin w_done = 1;  S_AXI_WVALID = 0; end
      if (w_done && !aw_done) chk("wready_low_while_held", 32'(S_AXI_WREADY), 0);
      if (aw_done && !w_done) chk("awready_low_while_held", 32'(S_AXI_AWREADY), 0);
      if (aw_done != w_done) begin
        chk("no_early_bvalid", 32'(S_AXI_BVALID), 0);
        chk("no_early_write", {gpio_out, gpio_oe}, snap);
      end
      n++;
    end
    chk("wr_handshake", 32'(aw_done && w_done), 1);
    chk("bvalid_next_cycle", 32'(S_AXI_BVALID), 1);
  endtask

  task automatic check_b();
    int n = 0;
    logic [1:0] e;
    while (S_AXI_BVALID !== 1'b1 && n < 20) begin step(); n++; end
    chk("bvalid_seen", 32'(S_AXI_BVALID), 1);
    chk("b_scoreboard_nonempty", 32'(bq.size() != 0), 1);
    if (bq.size() != 0) begin
      e = bq.pop_front();
      chk("bresp", 32'(S_AXI_BRESP), 32'(e));
    end
    S_AXI_BREADY = 1;
    step();
    chk("bvalid_clear", 32'(S_AXI_BVALID), 0);
  endtask

  task automatic txn_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input logic [1:0] er);
    bq.push_back(er);
    do_write(a, d, s, lead);
    check_b();
  endtask

  task automatic do_read(input logic [31:0] a);
    bit fired = 0, f;
    int n = 0;
    S_AXI_ARVALID = 1;
    S_AXI_ARADDR  = a;
    while (!fired && n < 20) begin
      f = S_AXI_ARREADY;
      step();
      if (f) fired = 1;
      n++;
    end
    S_AXI_ARVALID = 0;
    chk("ar_handshake", 32'(fired), 1);
    chk("rvalid_next_cycle", 32'(S_AXI_RVALID), 1);
  endtask

  task automatic check_r();
    int n = 0;
    logic [33:0] e;
    while (S_AXI_RVALID !== 1'b1 && n < 20) begin step(); n++; end
    chk("rvalid_seen", 32'(S_AXI_RVALID), 1);
    chk("r_scoreboard_nonempty", 32'(rq.size() != 0), 1);
    if (rq.size() != 0) begin
      e = rq.pop_front();
      chk("rdata", S_AXI_RDATA, e[33:2]);
      chk("rresp", 32'(S_AXI_RRESP), 32'(e[1:0]));
    end
    S_AXI_RREADY = 1;
    step();
    chk("rvalid_clear", 32'(S_AXI_RVALID), 0);
  endtask

  task automatic txn_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    rq.push_back({ed, er});
    do_read(a);
    check_r();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1, 0,  32'h0,   32'h0000A5A5, 4'b1111, 32'h0,    2'b00, 16'hA5A5, 16'h0000};
    vecs[1]  = '{1, 3,  32'h8,   32'h000000FF, 4'b0001, 32'h0,    2'b00, 16'hA5A5, 16'h00FF};
    vecs[2]  = '{1, 0,  32'hC,   32'h0000FFFF, 4'b1111, 32'h0,    2'b10, 16'hA5A5, 16'h00FF};
    vecs[3]  = '{1, 0,  32'h4,   32'h0000FFFF, 4'b1111, 32'h0,    2'b10, 16'hA5A5, 16'h00FF};
    vecs[4]  = '{0, 0,  32'hC,   32'h0,        4'b0000, 32'h0,    2'b10, 16'hA5A5, 16'h00FF};
    vecs[5]  = '{0, 0,  32'h0,   32'h0,        4'b0000, 32'hA5A5, 2'b00, 16'hA5A5, 16'h00FF};
    vecs[6]  = '{0, 0,  32'h8,   32'h0,        4'b0000, 32'h00FF, 2'b00, 16'hA5A5, 16'h00FF};
    vecs[7]  = '{1, 0,  32'h0,   32'hFFFF1234, 4'b0010, 32'h0,    2'b00, 16'h12A5, 16'h00FF};
    vecs[8]  = '{1, -2, 32'h10,  32'h000000C3, 4'b0001, 32'h0,    2'b00, 16'h12C3, 16'h00FF};
    vecs[9]  = '{0, 0,  32'h1F0, 32'h0,        4'b0000, 32'h12C3, 2'b00, 16'h12C3, 16'h00FF};
    vecs[10] = '{1, 1,  32'h0,   32'hFFFFFFFF, 4'b1100, 32'h0,    2'b00, 16'h12C3, 16'h00FF};
    vecs[11] = '{0, 0,  32'h3,   32'h0,        4'b0000, 32'h12C3, 2'b00, 16'h12C3, 16'h00FF};
    vecs[12] = '{1, 2,  32'hA,   32'h00005A00, 4'b0011, 32'h0,    2'b00, 16'h12C3, 16'h5A00};
    vecs[13] = '{0, 0,  32'h8,   32'h0,        4'b0000, 32'h5A00, 2'b00, 16'h12C3, 16'h5A00};
    vecs[14] = '{0, 0,  32'h4,   32'h0,        4'b0000, 32'hBEEF, 2'b00, 16'h12C3, 16'h5A00};

    reset = 1;
    S_AXI_AWVALID = 0; S_AXI_AWADDR = 0; S_AXI_AWPROT = 0;
    S_AXI_WVALID = 0;  S_AXI_WDATA = 0;  S_AXI_WSTRB = 0;
    S_AXI_BREADY = 1;
    S_AXI_ARVALID = 0; S_AXI_ARADDR = 0; S_AXI_ARPROT = 0;
    S_AXI_RREADY = 1;
    gpio_in = 16'hBEEF;
    repeat (3) step();
    chk_reset_outputs("reset");

    reset = 0;
    step();
    chk("ready_first_edge_aw", 32'(S_AXI_AWREADY), 0);
    chk("ready_first_edge_w",  32'(S_AXI_WREADY), 0);
    chk("ready_first_edge_ar", 32'(S_AXI_ARREADY), 0);
    step();
    chk("ready_after_init", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'h7);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr)
        txn_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead, vecs[i].exp_resp);
      else
        txn_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_resp);
      chk($sformatf("vec%0d_gpio_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_gpio_oe", i),  32'(gpio_oe),  32'(vecs[i].exp_oe));
    end

    // Pin change visible to IN reads after the synchronizer
    gpio_in = 16'h1234;
    repeat (3) step();
    txn_read(32'h4, 32'h00001234, 2'b00);

    // Read and write to OUT on the same edge: read returns the old value
    fork
      txn_write(32'h0, 32'h00007777, 4'b1111, 0, 2'b00);
      txn_read(32'h0, 32'h000012C3, 2'b00);
    join
    txn_read(32'h0, 32'h00007777, 2'b00);

    // Write response backpressure
    S_AXI_BREADY = 0;
    bq.push_back(2'b00);
    do_write(32'h0, 32'h00003C3C, 4'b1111, 0);
    S_AXI_AWVALID = 1;
    S_AXI_AWADDR  = 32'h8;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_bvalid", 32'(S_AXI_BVALID), 1);
      chk("bp_bresp", 32'(S_AXI_BRESP), 0);
      chk("bp_aw_wready", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 0);
    end
    chk("bp_gpio_out", 32'(gpio_out), 32'h3C3C);
    check_b();
    chk("bp_awready_after_b", 32'(S_AXI_AWREADY), 1);
    S_AXI_AWVALID = 0;
    txn_write(32'h8, 32'h00000F0F, 4'b1111, 0, 2'b00);
    chk("bp_gpio_oe", 32'(gpio_oe), 32'h0F0F);

    // Reset while a read response is pending and an address is held
    S_AXI_RREADY = 0;
    do_read(32'h0);
    S_AXI_AWVALID = 1;
    S_AXI_AWADDR  = 32'h0;
    step();
    chk("pre_reset_aw_held", 32'(S_AXI_AWREADY), 0);
    chk("pre_reset_rvalid", 32'(S_AXI_RVALID), 1);
    reset = 1;
    #1;
    chk_reset_outputs("async_reset");
    step();
    step();
    reset = 0;
    S_AXI_AWVALID = 0;
    S_AXI_RREADY  = 1;
    step();
    step();
    chk("post_reset_rvalid", 32'(S_AXI_RVALID), 0);
    txn_write(32'h0, 32'h00000BAD, 4'b1111, 0, 2'b00);
    chk("post_reset_gpio_out", 32'(gpio_out), 32'h0BAD);
    chk("post_reset_gpio_oe", 32'(gpio_oe), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
